mem_write_logger: RTL and testbench

- Sits directly downstream of the processor's memory stage and consumes the same store stream that goes to data RAM: write enable, 16-bit address and 48-bit data.
- Buffers each store record in a small FIFO.
- Serializes each record into an 8-byte stream over a valid/ready byte interface, toward a UART or text-dump sink.
- Replaces the combinational txt-dump taps with a lossless-until-full, flow-controlled path.

---
 rtl/log_pkg.sv | 25 ++
 rtl/mem_write_logger_if.sv | 26 ++
 rtl/log_fifo.sv | 55 +++++
 rtl/mem_write_logger.sv | 108 ++++++++++
 tb/tb_mem_write_logger.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/log_pkg.sv
// Shared types and helpers for the store-stream logger.
// Latency: none (declarations only).
// Backpressure: n/a.
package log_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } log_state_e;

  // Default store geometry; the record struct below matches it.
  localparam int LOG_ADDR_W = 16;
  localparam int LOG_DATA_W = 48;

  typedef struct packed {
    logic [LOG_ADDR_W-1:0] addr;
    logic [LOG_DATA_W-1:0] data;
  } log_rec_t;

  // Bytes emitted per record: address bytes followed by data bytes.
  function automatic int bytes_per_rec(input int addr_w, input int data_w);
    return (addr_w + data_w) / 8;
  endfunction

endpackage

// File: rtl/mem_write_logger_if.sv
// Store-side strobe/address/data plus the byte-serial valid/ready tx link.
// Latency: none (wiring only).
// Backpressure: tx_ready from the sink stalls tx_valid/tx_byte/tx_last.
// Ports: master = store source + byte sink (testbench side), slave = logger.
interface mem_write_logger_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 48
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_byte;
  logic              tx_last;

  modport master (
    output wr_en, wr_addr, wr_data, tx_ready,
    input  tx_valid, tx_byte, tx_last
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, tx_ready,
    output tx_valid, tx_byte, tx_last
  );
endinterface

// File: rtl/log_fifo.sv
// Synchronous first-word-fall-through FIFO holding whole store records.
// Latency: a push is visible at head one edge later; head is combinational.
// Backpressure: pushes while full are ignored unless a pop shares the edge.
// Ports: clk, rst (async active-low), push/push_data, pop, head, full, empty, count.
module log_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mem_write_logger.sv
// Buffers memory-stage stores and serializes each as address+data bytes, MSB first.
// Latency: store at edge N on an idle logger -> first byte valid after edge N+1; 1 byte/cycle.
// Backpressure: tx_ready low holds the current byte; stores arriving while full are dropped and counted.
// Ports: clk, rst (async active-low), bus (slave: store in, byte out), fifo_full, overflow, drop_count, busy.
module mem_write_logger
  import log_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 48
) (
  input  logic                clk,
  input  logic                rst,
  mem_write_logger_if.slave   bus,
  output logic                fifo_full,
  output logic                overflow,
  output logic [7:0]          drop_count,
  output logic                busy
);
  localparam int BPR   = bytes_per_rec(ADDR_W, DATA_W);
  localparam int REC_W = ADDR_W + DATA_W;
  localparam int IDX_W = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  log_state_e        state;
  logic [REC_W-1:0]  shreg;
  logic [IDX_W-1:0]  idx;
  logic [REC_W-1:0]  head;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              last_byte;
  logic              hs;
  logic              pop;
  logic              push;
  logic              drop;

  assign last_byte = (idx == IDX_W'(BPR - 1));
  assign hs        = (state == SEND) && bus.tx_ready;
  // Load from IDLE, or chain straight into the next record on the final handshake.
  assign pop       = !empty && ((state == IDLE) || (hs && last_byte));
  assign push      = bus.wr_en && (!full || pop);
  assign drop      = bus.wr_en && full && !pop;

  log_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({bus.wr_addr, bus.wr_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg <= head;
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            if (!last_byte) begin
              shreg <= shreg << 8;
              idx   <= idx + IDX_W'(1);
            end else if (pop) begin
              shreg <= head;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // Outputs are decoded straight from registered state, so they hold while stalled.
  assign bus.tx_valid = (state == SEND);
  assign bus.tx_byte  = shreg[REC_W-1 -: 8];
  assign bus.tx_last  = (state == SEND) && last_byte;
  assign fifo_full    = full;
  assign busy         = (count != '0) || (state == SEND);
endmodule

// File: tb/tb_mem_write_logger.sv
module tb_mem_write_logger;
  import log_pkg::*;

  localparam int DEPTH = 8;
  localparam int BPR   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_full;
  logic       overflow;
  logic [7:0] drop_count;
  logic       busy;

  always #5 clk = ~clk;

  mem_write_logger_if #(.ADDR_W(16), .DATA_W(48)) bus ();

  mem_write_logger #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(48)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .drop_count (drop_count),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: queue of buffered records plus the record being sent.
  log_rec_t   m_fifo[$];
  log_rec_t   m_cur;
  int         m_idx;
  bit         m_send;
  bit         m_ovf;
  int         m_drops;
  // Observed handshaked bytes.
  logic [7:0] got[$];
  logic       got_last[$];
  log_rec_t   z = '0;

  function automatic logic [7:0] rec_byte(input log_rec_t r, input int i);
    logic [63:0] f;
    f = {r.addr, r.data};
    return f[63-8*i -: 8];
  endfunction

  function automatic log_rec_t rand_rec();
    log_rec_t r;
    r.addr = 16'($urandom);
    r.data = {16'($urandom), $urandom};
    return r;
  endfunction

  task automatic model_clear();
    m_fifo.delete();
    m_cur = '0; m_idx = 0; m_send = 0; m_ovf = 0; m_drops = 0;
    got.delete(); got_last.delete();
  endtask

  // Called at a negedge: drive inputs, advance one rising edge, update model, return at next negedge.
  task automatic cycle(input bit en, input log_rec_t r, input bit rdy);
    bit hs, fin, pop, room;
    bus.wr_en = en; bus.wr_addr = r.addr; bus.wr_data = r.data; bus.tx_ready = rdy;
    if (bus.tx_valid === 1'b1 && rdy) begin
      got.push_back(bus.tx_byte);
      got_last.push_back(bus.tx_last);
    end
    @(posedge clk);
    hs   = m_send && rdy;
    fin  = hs && (m_idx == BPR - 1);
    pop  = (m_fifo.size() > 0) && (!m_send || fin);
    room = (m_fifo.size() < DEPTH) || pop;
    if (hs) begin
      if (fin) m_send = 0;
      else     m_idx++;
    end
    if (pop) begin
      m_cur = m_fifo.pop_front(); m_idx = 0; m_send = 1;
    end
    if (en) begin
      if (room) m_fifo.push_back(r);
      else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget, output bit timed_out);
    int n = 0;
    while ((m_send || m_fifo.size() > 0) && n < budget) begin
      cycle(0, z, 1);
      n++;
    end
    timed_out = (m_send || m_fifo.size() > 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.wr_en = 0; bus.tx_ready = 0;
    @(negedge clk);
    model_clear();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.tx_ready = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    checks += 7;
    if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
    if (bus.tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got=%h exp=00", bus.tx_byte); end
    if (bus.tx_last !== 1'b0) begin errors++; $display("FAIL reset_tx_last got=%b exp=0", bus.tx_last); end
    if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full got=%b exp=0", fifo_full); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    log_rec_t r;
    logic [7:0] exp_b [8];
    exp_b = '{8'h12, 8'h34, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    r.addr = 16'h1234; r.data = 48'hA1B2C3D4E5F6;
    cycle(1, r, 1);
    checks += 2;
    if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL single_lat_early got=%b exp=0", bus.tx_valid); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_queued got=%b exp=1", busy); end
    cycle(0, z, 1);
    for (int i = 0; i < 8; i++) begin
      checks += 3;
      if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d] got=%b exp=1", i, bus.tx_valid); end
      if (bus.tx_byte !== exp_b[i]) begin errors++; $display("FAIL single_byte[%0d] got=%h exp=%h", i, bus.tx_byte, exp_b[i]); end
      if (bus.tx_last !== (i == 7)) begin errors++; $display("FAIL single_last[%0d] got=%b exp=%b", i, bus.tx_last, (i == 7)); end
      cycle(0, z, 1);
    end
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL single_valid_end got=%b exp=0", bus.tx_valid); end
  endtask

  task automatic test_back_to_back();
    log_rec_t recs[3];
    logic [7:0] exp_q[$];
    int bubbles = 0;
    int cyc = 0;
    got.delete(); got_last.delete();
    foreach (recs[k]) begin
      recs[k] = rand_rec();
      for (int i = 0; i < BPR; i++) exp_q.push_back(rec_byte(recs[k], i));
    end
    while (cyc < 3 || ((m_send || m_fifo.size() > 0) && cyc < 60)) begin
      if (got.size() > 0 && got.size() < 24 && bus.tx_valid !== 1'b1) bubbles++;
      if (m_send) begin
        checks += 2;
        if (bus.tx_byte !== rec_byte(m_cur, m_idx)) begin errors++; $display("FAIL b2b_model_byte got=%h exp=%h", bus.tx_byte, rec_byte(m_cur, m_idx)); end
        if (bus.tx_last !== (m_idx == BPR - 1)) begin errors++; $display("FAIL b2b_model_last got=%b exp=%b", bus.tx_last, (m_idx == BPR - 1)); end
      end
      cycle(cyc < 3, (cyc < 3) ? recs[cyc] : z, 1);
      cyc++;
    end
    checks += 3;
    if (cyc >= 60) begin errors++; $display("FAIL b2b_timeout got=%0d cycles exp<60", cyc); end
    if (bubbles != 0) begin errors++; $display("FAIL b2b_bubbles got=%0d exp=0", bubbles); end
    if (got.size() != 24) begin errors++; $display("FAIL b2b_count got=%0d exp=24", got.size()); end
    for (int i = 0; i < 24 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    log_rec_t r;
    bit prev_stall = 0;
    logic [7:0] prev_byte = '0;
    logic prev_last = 0;
    int cyc = 0;
    bit rdy;
    r = rand_rec();
    got.delete(); got_last.delete();
    while (cyc == 0 || ((m_send || m_fifo.size() > 0) && cyc < 40)) begin
      rdy = cyc[0];
      if (prev_stall) begin
        checks += 3;
        if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_drop got=%b exp=1", bus.tx_valid); end
        if (bus.tx_byte !== prev_byte) begin errors++; $display("FAIL bp_byte_hold got=%h exp=%h", bus.tx_byte, prev_byte); end
        if (bus.tx_last !== prev_last) begin errors++; $display("FAIL bp_last_hold got=%b exp=%b", bus.tx_last, prev_last); end
      end
      prev_stall = (bus.tx_valid === 1'b1) && !rdy;
      prev_byte = bus.tx_byte;
      prev_last = bus.tx_last;
      cycle(cyc == 0, r, rdy);
      cyc++;
    end
    checks += 2;
    if (cyc >= 40) begin errors++; $display("FAIL bp_timeout got=%0d cycles exp<40", cyc); end
    if (got.size() != 8) begin errors++; $display("FAIL bp_handshakes got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== rec_byte(r, i)) begin errors++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, got[i], rec_byte(r, i)); end
    end
  endtask

  task automatic test_overflow();
    log_rec_t recs[10];
    int nlast = 0;
    bit to;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      recs[k] = rand_rec();
      cycle(1, recs[k], 0);
      if (k == 7 || k == 8) begin
        checks++;
        if (fifo_full !== (k == 8)) begin errors++; $display("FAIL ovf_full_after[%0d] got=%b exp=%b", k, fifo_full, (k == 8)); end
      end
    end
    checks += 4;
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", fifo_full); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    if (drop_count !== 8'd1) begin errors++; $display("FAIL ovf_drops got=%0d exp=1", drop_count); end
    if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL ovf_stalled_valid got=%b exp=1", bus.tx_valid); end
    drain(200, to);
    foreach (got_last[i]) if (got_last[i]) nlast++;
    checks += 3;
    if (to) begin errors++; $display("FAIL ovf_drain_timeout got=busy exp=idle"); end
    if (nlast != 9) begin errors++; $display("FAIL ovf_records got=%0d exp=9", nlast); end
    if (got.size() != 72) begin errors++; $display("FAIL ovf_bytes got=%0d exp=72", got.size()); end
    for (int i = 0; i < 72 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== rec_byte(recs[i/8], i%8)) begin errors++; $display("FAIL ovf_byte[%0d] got=%h exp=%h", i, got[i], rec_byte(recs[i/8], i%8)); end
    end
  endtask

  task automatic test_full_pop_push();
    log_rec_t recs[10];
    bit to;
    do_reset();
    for (int k = 0; k < 10; k++) recs[k] = rand_rec();
    for (int k = 0; k < 9; k++) cycle(1, recs[k], 0);
    repeat (7) cycle(0, z, 1);
    checks += 2;
    if (bus.tx_last !== 1'b1) begin errors++; $display("FAIL fpp_at_last got=%b exp=1", bus.tx_last); end
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL fpp_full_before got=%b exp=1", fifo_full); end
    cycle(1, recs[9], 1);
    checks += 4;
    if (drop_count !== 8'd0) begin errors++; $display("FAIL fpp_drops got=%0d exp=0", drop_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL fpp_full_after got=%b exp=1", fifo_full); end
    if (bus.tx_byte !== recs[1].addr[15:8]) begin errors++; $display("FAIL fpp_next_first got=%h exp=%h", bus.tx_byte, recs[1].addr[15:8]); end
    drain(200, to);
    checks += 2;
    if (to) begin errors++; $display("FAIL fpp_drain_timeout got=busy exp=idle"); end
    if (got.size() != 80) begin errors++; $display("FAIL fpp_bytes got=%0d exp=80", got.size()); end
    for (int i = 0; i < 80 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== rec_byte(recs[i/8], i%8)) begin errors++; $display("FAIL fpp_byte[%0d] got=%h exp=%h", i, got[i], rec_byte(recs[i/8], i%8)); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 270; k++) cycle(1, rand_rec(), 0);
    checks += 3;
    if (drop_count !== 8'(m_drops)) begin errors++; $display("FAIL sat_model got=%0d exp=%0d", drop_count, m_drops); end
    if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_drops got=%0d exp=255", drop_count); end
    if (overflow !== m_ovf) begin errors++; $display("FAIL sat_overflow got=%b exp=%b", overflow, m_ovf); end
  endtask

  task automatic test_reset_mid();
    log_rec_t r, r2;
    bit to;
    do_reset();
    r = rand_rec();
    cycle(1, r, 1);
    repeat (4) cycle(0, z, 1);
    checks++;
    if (bus.tx_byte !== rec_byte(r, 3)) begin errors++; $display("FAIL mid_pre_byte got=%h exp=%h", bus.tx_byte, rec_byte(r, 3)); end
    #2 rst = 1'b0;
    #1;
    checks += 5;
    if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_valid got=%b exp=0", bus.tx_valid); end
    if (bus.tx_byte !== 8'h00) begin errors++; $display("FAIL mid_tx_byte got=%h exp=00", bus.tx_byte); end
    if (bus.tx_last !== 1'b0) begin errors++; $display("FAIL mid_tx_last got=%b exp=0", bus.tx_last); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (fifo_full !== 1'b0) begin errors++; $display("FAIL mid_fifo_full got=%b exp=0", fifo_full); end
    @(negedge clk);
    model_clear();
    rst = 1'b1;
    @(negedge clk);
    r2 = rand_rec();
    cycle(1, r2, 1);
    cycle(0, z, 1);
    checks += 2;
    if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid got=%b exp=1", bus.tx_valid); end
    if (bus.tx_byte !== r2.addr[15:8]) begin errors++; $display("FAIL mid_new_first got=%h exp=%h", bus.tx_byte, r2.addr[15:8]); end
    drain(40, to);
    checks += 2;
    if (to) begin errors++; $display("FAIL mid_drain_timeout got=busy exp=idle"); end
    if (got.size() != 8) begin errors++; $display("FAIL mid_new_bytes got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== rec_byte(r2, i)) begin errors++; $display("FAIL mid_byte[%0d] got=%h exp=%h", i, got[i], rec_byte(r2, i)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_full_pop_push();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
